// File: rtl/frame_seq_pkg.sv
// Shared types and constants for the ENTER/LEAVE stack-frame sequencer.
// The register-write codes are also consumed by the EBP register-write decoder.
package frame_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_E_PUSH,
    S_E_EBP,
    S_E_SUB,
    S_L_ESP,
    S_L_POP,
    S_L_WB,
    S_DONE
  } state_e;

  localparam logic OP_ENTER = 1'b0;
  localparam logic OP_LEAVE = 1'b1;

  localparam logic [3:0] EBP_WR_CODE = 4'h2;
  localparam logic [3:0] RW_NONE     = 4'h0;

endpackage

// File: rtl/frame_seq_watchdog.sv
// Memory-ack watchdog: counts cycles a request is held unanswered and flags
// expiry on the LIMIT-th such cycle. Used only with FRAME_SEQ_TIMEOUT_EN.
module frame_seq_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clock_4,
  input  logic reset,
  input  logic req_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = '0;
    if (req_i && !ack_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_4 or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the cycles already waited, so the current cycle is the LIMIT-th.
  assign expired_o = req_i && !ack_i && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/frame_seq_ctrl.sv
// ENTER/LEAVE stack-frame sequencer driving ordered EBP/ESP writes and one stack
// memory access per operation. Optional memory-ack watchdog: FRAME_SEQ_TIMEOUT_EN.
module frame_seq_ctrl
  import frame_seq_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned STACK_STEP     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clock_4,
  input  logic              reset,
  input  logic              op_valid,
  input  logic              op_code,
  input  logic [15:0]       frame_size,
  output logic              op_ready,
  input  logic [DATA_W-1:0] cur_ebp,
  input  logic [DATA_W-1:0] cur_esp,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        ebp_rw_code,
  output logic [DATA_W-1:0] ebp_wdata,
  output logic              esp_we,
  output logic [DATA_W-1:0] esp_wdata,
  output logic              done,
  output logic              err
);

  localparam logic [DATA_W-1:0] STEP = DATA_W'(STACK_STEP);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ebp_q, ebp_d;
  logic [DATA_W-1:0] esp_q, esp_d;
  logic [DATA_W-1:0] pop_q, pop_d;
  logic [15:0]       size_q, size_d;
  logic              wd_expired;

`ifdef FRAME_SEQ_TIMEOUT_EN
  logic err_q;

  frame_seq_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock_4   (clock_4),
    .reset     (reset),
    .req_i     (mem_req),
    .ack_i     (mem_ack),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clock_4 or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (wd_expired) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign wd_expired = 1'b0;
  assign err        = 1'b0;

  // The watchdog limit has no effect without the watchdog.
  if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
  end
`endif

  always_ff @(posedge clock_4 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (op_valid) state_d = (op_code == OP_LEAVE) ? S_L_ESP : S_E_PUSH;
      S_E_PUSH: begin
        if (mem_ack)         state_d = S_E_EBP;
        else if (wd_expired) state_d = S_DONE;
      end
      S_E_EBP:  state_d = (size_q == '0) ? S_DONE : S_E_SUB;
      S_E_SUB:  state_d = S_DONE;
      S_L_ESP:  state_d = S_L_POP;
      S_L_POP: begin
        if (mem_ack)         state_d = S_L_WB;
        else if (wd_expired) state_d = S_DONE;
      end
      S_L_WB:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ebp_d  = ebp_q;
    esp_d  = esp_q;
    pop_d  = pop_q;
    size_d = size_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          ebp_d  = cur_ebp;
          esp_d  = cur_esp;
          size_d = frame_size;
        end
      end
      S_E_PUSH: if (mem_ack) esp_d = esp_q - STEP;
      S_L_ESP:  esp_d = ebp_q;
      S_L_POP:  if (mem_ack) pop_d = mem_rdata;
      default: ;
    endcase
  end

  always_ff @(posedge clock_4 or posedge reset) begin
    if (reset) begin
      ebp_q  <= '0;
      esp_q  <= '0;
      pop_q  <= '0;
      size_q <= '0;
    end else begin
      ebp_q  <= ebp_d;
      esp_q  <= esp_d;
      pop_q  <= pop_d;
      size_q <= size_d;
    end
  end

  // Outputs decode the state register only, so reset clears them without a clock.
  always_comb begin
    op_ready    = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    ebp_rw_code = RW_NONE;
    ebp_wdata   = '0;
    esp_we      = 1'b0;
    esp_wdata   = '0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: op_ready = 1'b1;
      S_E_PUSH: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = esp_q - STEP;
        mem_wdata = ebp_q;
      end
      S_E_EBP: begin
        ebp_rw_code = EBP_WR_CODE;
        ebp_wdata   = esp_q;
        esp_we      = 1'b1;
        esp_wdata   = esp_q;
      end
      S_E_SUB: begin
        esp_we    = 1'b1;
        esp_wdata = esp_q - DATA_W'(size_q);
      end
      S_L_ESP: begin
        esp_we    = 1'b1;
        esp_wdata = ebp_q;
      end
      S_L_POP: begin
        mem_req  = 1'b1;
        mem_addr = esp_q;
      end
      S_L_WB: begin
        ebp_rw_code = EBP_WR_CODE;
        ebp_wdata   = pop_q;
        esp_we      = 1'b1;
        esp_wdata   = esp_q + STEP;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Directed self-checking bench for frame_seq_ctrl; timeout scenario is built
// when FRAME_SEQ_TIMEOUT_EN is defined.
module tb_frame_seq_ctrl;
  import frame_seq_pkg::*;

  logic        clock_4 = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_code;
  logic [15:0] frame_size;
  logic        op_ready;
  logic [31:0] cur_ebp, cur_esp;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [3:0]  ebp_rw_code;
  logic [31:0] ebp_wdata;
  logic        esp_we;
  logic [31:0] esp_wdata;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          done_cyc;
    int          req_cyc;
    int          esp_wr;
    int          ebp_wr;
    int          bad_code;
    int          unstable;
    logic        req_we;
    logic        overlap;
    logic        ready_after;
    logic        done_after;
    logic        err_after;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] esp_first;
    logic [31:0] esp_last;
    logic [31:0] ebp_last;
  } obs_t;

  frame_seq_ctrl #(
    .DATA_W         (32),
    .STACK_STEP     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock_4     (clock_4),
    .reset       (reset),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .frame_size  (frame_size),
    .op_ready    (op_ready),
    .cur_ebp     (cur_ebp),
    .cur_esp     (cur_esp),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .ebp_rw_code (ebp_rw_code),
    .ebp_wdata   (ebp_wdata),
    .esp_we      (esp_we),
    .esp_wdata   (esp_wdata),
    .done        (done),
    .err         (err)
  );

  always #5 clock_4 = ~clock_4;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global time limit reached");
  end

  // Presents one op, then serves/observes cycles 1..budget after the accept edge.
  // ack_wait = unanswered request cycles before mem_ack (-1 = never acknowledge).
  task automatic run_op(input logic code, input logic [15:0] size,
                        input logic [31:0] ebp, input logic [31:0] esp,
                        input int ack_wait, input logic [31:0] rdata,
                        input int budget, output obs_t o);
    o = '{default: 0};
    @(negedge clock_4);
    op_valid = 1'b1; op_code = code; frame_size = size; cur_ebp = ebp; cur_esp = esp;
    @(posedge clock_4);
    @(negedge clock_4);
    op_valid = 1'b0; op_code = ~code; frame_size = 16'hFFFF;
    cur_ebp = 32'h5A5A_5A5A; cur_esp = 32'hA5A5_A5A5;
    for (int n = 1; n <= budget; n++) begin
      if (done && op_ready) o.overlap = 1'b1;
      if (ebp_rw_code == EBP_WR_CODE) begin
        o.ebp_wr++; o.ebp_last = ebp_wdata;
      end else if (ebp_rw_code != RW_NONE) begin
        o.bad_code++;
      end
      if (esp_we) begin
        if (o.esp_wr == 0) o.esp_first = esp_wdata;
        o.esp_last = esp_wdata; o.esp_wr++;
      end
      mem_ack = 1'b0;
      mem_rdata = 32'hBAD0_0000 | 32'(n);
      if (mem_req) begin
        if (o.req_cyc == 0) begin
          o.req_we = mem_we; o.req_addr = mem_addr; o.req_wdata = mem_wdata;
        end else if ({mem_we, mem_addr, mem_wdata} != {o.req_we, o.req_addr, o.req_wdata}) begin
          o.unstable++;
        end
        if (o.req_cyc == ack_wait) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end
        o.req_cyc++;
      end
      if (done) begin
        o.done_cyc = n;
        break;
      end
      @(negedge clock_4);
    end
    mem_ack = 1'b0;
    if (o.done_cyc != 0) @(negedge clock_4);
    o.ready_after = op_ready; o.done_after = done; o.err_after = err;
  endtask

  task automatic test_reset;
    reset = 1'b1; op_valid = 1'b0; op_code = 1'b0; frame_size = '0;
    cur_ebp = '0; cur_esp = '0; mem_ack = 1'b0; mem_rdata = '0;
    #1;
    checks++;
    if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", op_ready); end
    checks++;
    if ({mem_req, mem_we, esp_we, done, err} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 00000", {mem_req, mem_we, esp_we, done, err});
    end
    checks++;
    if ({mem_addr, mem_wdata, ebp_wdata, esp_wdata, ebp_rw_code} !== 132'b0) begin
      errors++; $display("FAIL reset_buses: addr %h wdata %h ebp %h esp %h code %h want all 0",
                         mem_addr, mem_wdata, ebp_wdata, esp_wdata, ebp_rw_code);
    end
    repeat (2) @(negedge clock_4);
    reset = 1'b0;
    @(negedge clock_4);
    checks++;
    if (op_ready !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: ready %b req %b want 1 0", op_ready, mem_req);
    end
  endtask

  task automatic test_enter;
    obs_t o;
    run_op(OP_ENTER, 16'h0010, 32'h0000_0999, 32'h0000_1000, 0, 32'h0, 30, o);
    checks++;
    if (o.req_we !== 1'b1 || o.req_addr !== 32'h0FFC || o.req_wdata !== 32'h0999) begin
      errors++; $display("FAIL enter_push: we %b addr %h data %h want 1 00000ffc 00000999",
                         o.req_we, o.req_addr, o.req_wdata);
    end
    checks++;
    if (o.ebp_wr != 1 || o.ebp_last !== 32'h0FFC || o.bad_code != 0) begin
      errors++; $display("FAIL enter_ebp: writes %0d data %h badcode %0d want 1 00000ffc 0",
                         o.ebp_wr, o.ebp_last, o.bad_code);
    end
    checks++;
    if (o.esp_wr != 2 || o.esp_first !== 32'h0FFC || o.esp_last !== 32'h0FEC) begin
      errors++; $display("FAIL enter_esp: writes %0d first %h last %h want 2 00000ffc 00000fec",
                         o.esp_wr, o.esp_first, o.esp_last);
    end
    checks++;
    if (o.done_cyc != 4) begin errors++; $display("FAIL enter_latency: got %0d want 4", o.done_cyc); end
    checks++;
    if (o.ready_after !== 1'b1 || o.done_after !== 1'b0 || o.overlap !== 1'b0) begin
      errors++; $display("FAIL enter_handoff: ready %b done %b overlap %b want 1 0 0",
                         o.ready_after, o.done_after, o.overlap);
    end
  endtask

  task automatic test_leave;
    obs_t o;
    run_op(OP_LEAVE, 16'h0000, 32'h0000_0FFC, 32'h0000_0FEC, 3, 32'h0000_0999, 30, o);
    checks++;
    if (o.esp_first !== 32'h0FFC) begin
      errors++; $display("FAIL leave_esp_restore: got %h want 00000ffc", o.esp_first);
    end
    checks++;
    if (o.req_we !== 1'b0 || o.req_addr !== 32'h0FFC || o.req_cyc != 4 || o.unstable != 0) begin
      errors++; $display("FAIL leave_pop: we %b addr %h cycles %0d unstable %0d want 0 00000ffc 4 0",
                         o.req_we, o.req_addr, o.req_cyc, o.unstable);
    end
    checks++;
    if (o.ebp_wr != 1 || o.ebp_last !== 32'h0999) begin
      errors++; $display("FAIL leave_ebp: writes %0d data %h want 1 00000999", o.ebp_wr, o.ebp_last);
    end
    checks++;
    if (o.esp_wr != 2 || o.esp_last !== 32'h1000) begin
      errors++; $display("FAIL leave_esp_final: writes %0d last %h want 2 00001000", o.esp_wr, o.esp_last);
    end
    checks++;
    if (o.done_cyc != 7 || o.ready_after !== 1'b1) begin
      errors++; $display("FAIL leave_latency: done %0d ready %b want 7 1", o.done_cyc, o.ready_after);
    end
  endtask

  task automatic test_enter_zero_size;
    obs_t o;
    run_op(OP_ENTER, 16'h0000, 32'h0000_1234, 32'h0000_2000, 0, 32'h0, 30, o);
    checks++;
    if (o.done_cyc != 3) begin errors++; $display("FAIL zero_latency: got %0d want 3", o.done_cyc); end
    checks++;
    if (o.esp_wr != 1 || o.esp_last !== 32'h1FFC || o.ebp_last !== 32'h1FFC || o.req_wdata !== 32'h1234) begin
      errors++; $display("FAIL zero_regs: espwr %0d esp %h ebp %h push %h want 1 00001ffc 00001ffc 00001234",
                         o.esp_wr, o.esp_last, o.ebp_last, o.req_wdata);
    end
  endtask

  task automatic test_wrap;
    obs_t o;
    run_op(OP_ENTER, 16'h0008, 32'hDEAD_BEEF, 32'h0000_0002, 0, 32'h0, 30, o);
    checks++;
    if (o.req_addr !== 32'hFFFF_FFFE || o.req_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wrap_push: addr %h data %h want fffffffe deadbeef", o.req_addr, o.req_wdata);
    end
    checks++;
    if (o.ebp_last !== 32'hFFFF_FFFE || o.esp_last !== 32'hFFFF_FFF6 || o.err_after !== 1'b0 || o.done_cyc != 4) begin
      errors++; $display("FAIL wrap_enter: ebp %h esp %h err %b done %0d want fffffffe fffffff6 0 4",
                         o.ebp_last, o.esp_last, o.err_after, o.done_cyc);
    end
    run_op(OP_LEAVE, 16'h0000, 32'hFFFF_FFFC, 32'h0000_0000, 0, 32'h1234_5678, 30, o);
    checks++;
    if (o.req_addr !== 32'hFFFF_FFFC || o.esp_last !== 32'h0 || o.ebp_last !== 32'h1234_5678 || o.done_cyc != 4) begin
      errors++; $display("FAIL wrap_leave: addr %h esp %h ebp %h done %0d want fffffffc 00000000 12345678 4",
                         o.req_addr, o.esp_last, o.ebp_last, o.done_cyc);
    end
  endtask

  task automatic test_busy_and_reset;
    @(negedge clock_4);
    op_valid = 1'b1; op_code = OP_LEAVE; cur_ebp = 32'h0000_3000; cur_esp = 32'h0000_2F00;
    @(posedge clock_4);
    @(negedge clock_4);
    op_valid = 1'b0;
    @(posedge clock_4);
    @(negedge clock_4);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h3000) begin
      errors++; $display("FAIL pop_wait: req %b we %b addr %h want 1 0 00003000", mem_req, mem_we, mem_addr);
    end
    op_valid = 1'b1; op_code = OP_ENTER; cur_esp = 32'h0000_8000; frame_size = 16'h0040;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock_4);
      @(negedge clock_4);
      checks++;
      if (op_ready !== 1'b0 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h3000) begin
        errors++; $display("FAIL busy_ignore: ready %b req %b we %b addr %h want 0 1 0 00003000",
                           op_ready, mem_req, mem_we, mem_addr);
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || esp_we !== 1'b0 || ebp_rw_code !== RW_NONE || op_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset_pop: req %b espwe %b code %h ready %b want 0 0 0 1",
                         mem_req, esp_we, ebp_rw_code, op_ready);
    end
    op_valid = 1'b0;
    @(negedge clock_4);
    reset = 1'b0;
    @(negedge clock_4);
    checks++;
    if (op_ready !== 1'b1 || mem_req !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_idle: ready %b req %b done %b want 1 0 0", op_ready, mem_req, done);
    end
  endtask

  task automatic test_reset_during_write;
    @(negedge clock_4);
    op_valid = 1'b1; op_code = OP_ENTER; frame_size = 16'h0010;
    cur_ebp = 32'h0000_6666; cur_esp = 32'h0000_7000;
    @(posedge clock_4);
    @(negedge clock_4);
    op_valid = 1'b0; mem_ack = 1'b1;
    @(posedge clock_4);
    @(negedge clock_4);
    mem_ack = 1'b0;
    checks++;
    if (esp_we !== 1'b1 || ebp_rw_code !== EBP_WR_CODE || ebp_wdata !== 32'h6FFC) begin
      errors++; $display("FAIL pre_reset_write: espwe %b code %h ebp %h want 1 2 00006ffc",
                         esp_we, ebp_rw_code, ebp_wdata);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (esp_we !== 1'b0 || ebp_rw_code !== RW_NONE || esp_wdata !== 32'h0 || ebp_wdata !== 32'h0) begin
      errors++; $display("FAIL async_reset_write: espwe %b code %h esp %h ebp %h want 0 0 0 0",
                         esp_we, ebp_rw_code, esp_wdata, ebp_wdata);
    end
    @(negedge clock_4);
    reset = 1'b0;
  endtask

`ifdef FRAME_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    obs_t o;
    run_op(OP_ENTER, 16'h0020, 32'h0000_4444, 32'h0000_4000, -1, 32'h0, 30, o);
    checks++;
    if (o.req_cyc != 8 || o.done_cyc != 9) begin
      errors++; $display("FAIL timeout_abort: req cycles %0d done %0d want 8 9", o.req_cyc, o.done_cyc);
    end
    checks++;
    if (o.ebp_wr != 0 || o.esp_wr != 0 || o.err_after !== 1'b1 || o.ready_after !== 1'b1) begin
      errors++; $display("FAIL timeout_effects: ebpwr %0d espwr %0d err %b ready %b want 0 0 1 1",
                         o.ebp_wr, o.esp_wr, o.err_after, o.ready_after);
    end
    run_op(OP_ENTER, 16'h0004, 32'h0000_5555, 32'h0000_5000, 0, 32'h0, 30, o);
    checks++;
    if (o.err_after !== 1'b1 || o.done_cyc != 4 || o.esp_last !== 32'h4FF8) begin
      errors++; $display("FAIL err_sticky: err %b done %0d esp %h want 1 4 00004ff8",
                         o.err_after, o.done_cyc, o.esp_last);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_reset: got %b want 0", err); end
    @(negedge clock_4);
    reset = 1'b0;
  endtask
`else
  task automatic test_no_timeout;
    obs_t o;
    run_op(OP_ENTER, 16'h0020, 32'h0000_4444, 32'h0000_4000, -1, 32'h0, 20, o);
    checks++;
    if (o.done_cyc != 0 || o.req_cyc != 20 || o.err_after !== 1'b0 || o.ebp_wr != 0) begin
      errors++; $display("FAIL stall_wait: done %0d req %0d err %b ebpwr %0d want 0 20 0 0",
                         o.done_cyc, o.req_cyc, o.err_after, o.ebp_wr);
    end
    reset = 1'b1;
    @(negedge clock_4);
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_enter();
    test_leave();
    test_enter_zero_size();
    test_wrap();
    test_busy_and_reset();
    test_reset_during_write();
`ifdef FRAME_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_enter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
